// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - round-robin arbiter sharing one CORDIC core among NREQ requesters
module cordic_arbiter #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   req_x,
   output logic [NREQ-1:0]      req_ack,
   output logic                 core_en,
   output logic [31:0]          core_x,
   input  logic [31:0]          core_epx,
   input  logic [31:0]          core_sinhx,
   input  logic [31:0]          core_coshx,
   input  logic                 core_valid,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic                 rsp_err,
   output logic [31:0]          rsp_epx,
   output logic [31:0]          rsp_sinhx,
   output logic [31:0]          rsp_coshx,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t         state, state_nxt;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] id;
   logic [IDW-1:0] win;
   logic           win_ok;
   logic [7:0]     cnt;
   logic           cnt_hit;
   logic [31:0]    x_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_x
      assign x_arr[g] = req_x[32*g +: 32];
   end

   assign cnt_hit = (cnt == 8'(TIMEOUT));

   // round-robin search: first active request at or after ptr, wrapping
   always_comb begin
      int j;
      j      = 0;
      win    = '0;
      win_ok = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!win_ok && req[IDW'(j)]) begin
            win    = IDW'(j);
            win_ok = 1'b1;
         end
      end
   end

   // state register; reset aborts any transaction in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // next state and the single-cycle strobes derived from the current state
   always_comb begin
      state_nxt = state;
      core_en   = 1'b0;
      req_ack   = '0;
      rsp_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE:  if (win_ok) state_nxt = ISSUE;
         ISSUE: begin
            core_en   = 1'b1;
            req_ack   = NREQ'(1) << id;
            state_nxt = WAIT;
         end
         WAIT:  if (core_valid || cnt_hit) state_nxt = DONE;
         DONE:  begin
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // datapath: winner latch, operand, rotation pointer, timeout counter, response capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr       <= '0;
         id        <= '0;
         core_x    <= '0;
         cnt       <= '0;
         rsp_id    <= '0;
         rsp_err   <= 1'b0;
         rsp_epx   <= '0;
         rsp_sinhx <= '0;
         rsp_coshx <= '0;
      end else begin
         case (state)
            IDLE: if (win_ok) begin
               id     <= win;
               core_x <= x_arr[win];
            end
            ISSUE: begin
               ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
               cnt <= '0;
            end
            WAIT: begin
               // a result arriving on the timeout cycle still counts as success
               if (core_valid) begin
                  rsp_id    <= id;
                  rsp_err   <= 1'b0;
                  rsp_epx   <= core_epx;
                  rsp_sinhx <= core_sinhx;
                  rsp_coshx <= core_coshx;
               end else if (cnt_hit) begin
                  rsp_id    <= id;
                  rsp_err   <= 1'b1;
                  rsp_epx   <= '0;
                  rsp_sinhx <= '0;
                  rsp_coshx <= '0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - self-checking bench for cordic_arbiter
module tb_cordic_arbiter;
   localparam int NREQ    = 4;
   localparam int IDW     = 2;
   localparam int TIMEOUT = 64;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req = '0;
   logic [32*NREQ-1:0]  req_x = '0;
   logic [NREQ-1:0]     req_ack;
   logic                core_en;
   logic [31:0]         core_x;
   logic [31:0]         core_epx = '0;
   logic [31:0]         core_sinhx = '0;
   logic [31:0]         core_coshx = '0;
   logic                core_valid = 1'b0;
   logic                rsp_valid;
   logic [IDW-1:0]      rsp_id;
   logic                rsp_err;
   logic [31:0]         rsp_epx;
   logic [31:0]         rsp_sinhx;
   logic [31:0]         rsp_coshx;
   logic                busy;

   cordic_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_ack(req_ack),
      .core_en(core_en), .core_x(core_x), .core_epx(core_epx),
      .core_sinhx(core_sinhx), .core_coshx(core_coshx), .core_valid(core_valid),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
      .rsp_epx(rsp_epx), .rsp_sinhx(rsp_sinhx), .rsp_coshx(rsp_coshx), .busy(busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // core emulator: answers core_valid core_lat cycles after core_en (0 = never)
   int          core_lat = 0;
   int          cd = 0;
   bit          extra_pulse = 0;
   bit          core_fire;
   int          n_pulse = 0;
   logic [31:0] last_epx = '0;
   logic [31:0] last_sinh = '0;
   logic [31:0] last_cosh = '0;

   initial forever begin
      @(posedge clk);
      #2;
      core_fire  = 0;
      core_valid = 1'b0;
      core_epx   = 32'hDEAD0000 | 32'(cyc);
      core_sinhx = 32'hBEEF0000 ^ 32'(cyc);
      core_coshx = ~32'(cyc);
      if (!rst) begin
         cd = 0;
      end else begin
         if (cd > 0) begin
            cd--;
            if (cd == 0) core_fire = 1;
         end
         if (core_en && core_lat > 0) cd = core_lat;
      end
      if (extra_pulse) begin
         core_fire   = 1;
         extra_pulse = 0;
      end
      if (core_fire) begin
         n_pulse++;
         core_valid = 1'b1;
         core_epx   = {8'hE1, 24'(n_pulse)};
         core_sinhx = {8'h51, 24'(n_pulse)};
         core_coshx = {8'hC0, 24'(n_pulse)};
         last_epx   = core_epx;
         last_sinh  = core_sinhx;
         last_cosh  = core_coshx;
      end
   end

   // transaction-level model: age counts cycles since the accept pulse
   int          m_t = -1;
   bit          m_done = 0;
   int          m_ptr = 0;
   int          m_id = 0;
   logic [31:0] m_x = '0;
   logic [31:0] m_epx = '0, m_sinh = '0, m_cosh = '0;
   int          m_rid = 0;
   bit          m_err = 0;

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_t = -1; m_done = 0; m_ptr = 0; m_id = 0; m_x = '0;
         m_epx = '0; m_sinh = '0; m_cosh = '0; m_rid = 0; m_err = 0;
      end else if (m_t < 0) begin
         if (req != '0) begin
            for (int k = NREQ - 1; k >= 0; k--)
               if (req[(m_ptr + k) % NREQ]) m_id = (m_ptr + k) % NREQ;
            m_x = req_x[32*m_id +: 32];
            m_t = 0;
         end
      end else if (m_done) begin
         m_t = -1;
         m_done = 0;
      end else if (m_t == 0) begin
         m_ptr = (m_id + 1) % NREQ;
         m_t = 1;
      end else if (core_valid) begin
         m_epx = core_epx; m_sinh = core_sinhx; m_cosh = core_coshx;
         m_err = 0; m_rid = m_id; m_done = 1;
      end else if (m_t == TIMEOUT + 1) begin
         m_epx = '0; m_sinh = '0; m_cosh = '0;
         m_err = 1; m_rid = m_id; m_done = 1;
      end else begin
         m_t++;
      end
   end

   // event logs filled by the compare process
   int en_cyc[$], rsp_cyc[$], ack_ids[$], rsp_ids[$], rsp_errs[$];
   logic prev_en = 0, prev_ack = 0, prev_rsp = 0;

   // compare every cycle on the falling edge
   initial forever begin
      @(negedge clk);
      chk("busy", busy, m_t >= 0);
      chk("core_en", core_en, m_t == 0);
      chk("req_ack", req_ack, (m_t == 0) ? (4'b0001 << m_id) : 4'b0000);
      chk("core_x", core_x, m_x);
      chk("rsp_valid", rsp_valid, m_done);
      chk("rsp_id", rsp_id, m_rid);
      chk("rsp_err", rsp_err, m_err);
      chk("rsp_epx", rsp_epx, m_epx);
      chk("rsp_sinhx", rsp_sinhx, m_sinh);
      chk("rsp_coshx", rsp_coshx, m_cosh);
      chk("en_single", core_en & prev_en, 0);
      chk("ack_single", (req_ack != 0) & prev_ack, 0);
      chk("rsp_single", rsp_valid & prev_rsp, 0);
      prev_en  = core_en;
      prev_ack = (req_ack != 0);
      prev_rsp = rsp_valid;
      if (core_en) en_cyc.push_back(cyc);
      for (int i = 0; i < NREQ; i++) if (req_ack[i]) ack_ids.push_back(i);
      if (rsp_valid) begin
         rsp_cyc.push_back(cyc);
         rsp_ids.push_back(int'(rsp_id));
         rsp_errs.push_back(int'(rsp_err));
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_q();
      en_cyc.delete(); rsp_cyc.delete(); ack_ids.delete();
      rsp_ids.delete(); rsp_errs.delete();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(1);
      clear_q();
   endtask

   task automatic wait_acks(input int target, input int budget, input string name);
      int k = 0;
      while (ack_ids.size() < target && k < budget) begin
         tick(1);
         k++;
      end
      chk(name, ack_ids.size() >= target, 1);
   endtask

   task automatic wait_rsp(input int target, input int budget, input string name);
      int k = 0;
      while (rsp_cyc.size() < target && k < budget) begin
         tick(1);
         k++;
      end
      chk(name, rsp_cyc.size() >= target, 1);
   endtask

   initial begin
      int c;
      int exp_order[5];
      exp_order = '{0, 1, 2, 3, 0};
      req_x = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00020000};
      #1 rst = 1'b0;
      tick(2);
      chk("rst_busy", busy, 0);
      chk("rst_core_x", core_x, 0);
      chk("rst_rsp_epx", rsp_epx, 0);
      rst = 1'b1;
      tick(2);
      clear_q();

      // single request, latency 18
      core_lat = 18;
      req = 4'b0001;
      c = cyc;
      wait_acks(1, 10, "t1_ack_wait");
      req = '0;
      wait_rsp(1, 40, "t1_rsp_wait");
      chk("t1_req_to_en", en_cyc[0] - c, 1);
      chk("t1_en_to_rsp", rsp_cyc[0] - en_cyc[0], 19);
      chk("t1_ack_id", ack_ids[0], 0);
      chk("t1_core_x", core_x, 32'h00020000);
      chk("t1_rsp_id", rsp_ids[0], 0);
      chk("t1_rsp_err", rsp_errs[0], 0);
      chk("t1_rsp_epx", rsp_epx, 32'hE1000001);
      chk("t1_rsp_sinhx", rsp_sinhx, 32'h51000001);
      chk("t1_rsp_coshx", rsp_coshx, 32'hC0000001);

      // all four requesting, latency 5
      do_reset();
      core_lat = 5;
      req = 4'b1111;
      wait_acks(5, 60, "t2_ack_wait");
      req = '0;
      wait_rsp(5, 30, "t2_rsp_wait");
      for (int i = 0; i < 5; i++) begin
         chk("t2_grant_order", ack_ids[i], exp_order[i]);
         chk("t2_rsp_id", rsp_ids[i], exp_order[i]);
      end
      for (int i = 0; i < 4; i++) chk("t2_period", en_cyc[i+1] - en_cyc[i], 8);

      // core never answers: timeout, then a normal request
      do_reset();
      core_lat = 0;
      req = 4'b0001;
      wait_acks(1, 10, "t3_ack_wait");
      req = '0;
      wait_rsp(1, 100, "t3_rsp_wait");
      chk("t3_en_to_rsp", rsp_cyc[0] - en_cyc[0], 66);
      chk("t3_err", rsp_errs[0], 1);
      chk("t3_epx_zero", rsp_epx, 0);
      chk("t3_sinhx_zero", rsp_sinhx, 0);
      chk("t3_coshx_zero", rsp_coshx, 0);
      core_lat = 3;
      req = 4'b0010;
      wait_acks(2, 10, "t3b_ack_wait");
      req = '0;
      wait_rsp(2, 20, "t3b_rsp_wait");
      chk("t3b_err", rsp_errs[1], 0);
      chk("t3b_id", rsp_ids[1], 1);
      chk("t3b_lat", rsp_cyc[1] - en_cyc[1], 4);
      chk("t3b_epx", rsp_epx, last_epx);

      // result on the timeout cycle wins; minimum latency of one
      clear_q();
      core_lat = 65;
      req = 4'b1000;
      wait_acks(1, 10, "t4_ack_wait");
      req = '0;
      wait_rsp(1, 100, "t4_rsp_wait");
      chk("t4_en_to_rsp", rsp_cyc[0] - en_cyc[0], 66);
      chk("t4_err", rsp_errs[0], 0);
      chk("t4_id", rsp_ids[0], 3);
      chk("t4_epx", rsp_epx, last_epx);
      core_lat = 1;
      req = 4'b0100;
      wait_acks(2, 10, "t4b_ack_wait");
      req = '0;
      wait_rsp(2, 20, "t4b_rsp_wait");
      chk("t4b_lat", rsp_cyc[1] - en_cyc[1], 2);

      // reset during WAIT, late core_valid after release
      clear_q();
      core_lat = 0;
      req = 4'b0001;
      wait_acks(1, 10, "t5_ack_wait");
      req = '0;
      tick(5);
      chk("t5_busy_wait", busy, 1);
      rst = 1'b0;
      #1;
      chk("t5_busy_rst", busy, 0);
      chk("t5_core_x_rst", core_x, 0);
      chk("t5_epx_rst", rsp_epx, 0);
      tick(2);
      rst = 1'b1;
      tick(3);
      extra_pulse = 1;
      tick(10);
      chk("t5_no_rsp", rsp_cyc.size(), 0);
      chk("t5_busy_after", busy, 0);

      // core_valid in IDLE and ISSUE ignored
      clear_q();
      core_lat = 4;
      extra_pulse = 1;
      tick(3);
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_no_rsp", rsp_cyc.size(), 0);
      req = 4'b0001;
      extra_pulse = 1;
      c = cyc;
      tick(1);
      extra_pulse = 1;
      req = '0;
      wait_rsp(1, 20, "t6_rsp_wait");
      tick(4);
      chk("t6_one_rsp", rsp_cyc.size(), 1);
      chk("t6_en_at", en_cyc[0] - c, 1);
      chk("t6_lat", rsp_cyc[0] - en_cyc[0], 5);
      chk("t6_err", rsp_errs[0], 0);
      chk("t6_epx", rsp_epx, last_epx);

      // winner committed although its request drops
      clear_q();
      core_lat = 2;
      req = 4'b0100;
      tick(1);
      req = '0;
      wait_rsp(1, 20, "t7_rsp_wait");
      chk("t7_ack_id", ack_ids[0], 2);
      chk("t7_rsp_id", rsp_ids[0], 2);
      chk("t7_lat", rsp_cyc[0] - en_cyc[0], 3);
      chk("t7_core_x", core_x, 32'h22222222);

      tick(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NREQ     4    number of requesters (2..8)
  IDW      2    requester id width, clog2(NREQ)
  TIMEOUT  64   WAIT cycles before abort (1..255)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk         in   1         single clock, rising edge
  rst         in   1         asynchronous, active-low reset
  req         in   NREQ      request per requester; level
  req_x       in   32*NREQ   operand, requester i at [32i+31:32i]
  req_ack     out  NREQ      one-hot, one-cycle accept pulse
  core_en     out  1         one-cycle start pulse to CORDIC core
  core_x      out  32        operand to core, registered
  core_epx    in   32        core e^x result
  core_sinhx  in   32        core sinh result
  core_coshx  in   32        core cosh result
  core_valid  in   1         core result valid
  rsp_valid   out  1         one-cycle response pulse
  rsp_id      out  IDW       requester served
  rsp_err     out  1         timeout flag, qualified by rsp_valid
  rsp_epx     out  32        captured e^x
  rsp_sinhx   out  32        captured sinh
  rsp_coshx   out  32        captured cosh
  busy        out  1         high in any state except IDLE

Function
REQ-003 FSM SHALL have states IDLE, ISSUE, WAIT, DONE; one transaction in flight at most.
REQ-004 IDLE: if req nonzero, SHALL select winner by round-robin starting at ptr, latch req_x of winner into core_x and id, go to ISSUE; else stay.
REQ-005 ISSUE (exactly one cycle): core_en=1, req_ack[id]=1, ptr <= id+1 modulo NREQ, timeout counter cleared, go to WAIT.
REQ-006 Winner is committed once latched in IDLE; deassertion of req afterwards SHALL NOT cancel the transaction.
REQ-007 WAIT: on core_valid SHALL capture core_epx/sinhx/coshx into rsp_* and go to DONE with rsp_err=0.
REQ-008 WAIT: counter increments each cycle without core_valid; when it reaches TIMEOUT, SHALL go to DONE with rsp_err=1 and rsp_epx/sinhx/coshx=0.
REQ-009 core_valid in IDLE, ISSUE or DONE SHALL be ignored; core_valid in the same cycle the counter reaches TIMEOUT SHALL win (rsp_err=0).
REQ-010 DONE (one cycle): rsp_valid=1, rsp_id=id; then IDLE; rsp_* data holds until next DONE.
REQ-011 Latency: req sampled in IDLE at cycle T -> core_en/req_ack at T+1; core_valid at T+1+L (L>=1) -> rsp_valid at T+2+L.
REQ-012 IDLE SHALL grant in the cycle it is entered; back-to-back transaction period is L+3 cycles.
REQ-013 Round-robin SHALL be starvation-free: with all req held high, grants cycle 0,1,...,NREQ-1,0.
REQ-014 req_ack, core_en, rsp_valid SHALL never be high for more than one consecutive cycle.

Reset
REQ-015 rst low SHALL immediately force IDLE, ptr=0, counter=0, and every output to 0, including mid-transaction.
REQ-016 A transaction aborted by reset SHALL produce no rsp_valid; a late core_valid after reset release SHALL be ignored.

Verification
REQ-017 Single request: req=0001, req_x[31:0]=32'h00020000, core returns valid 18 cycles after core_en -> core_x=32'h00020000, req_ack=0001 with core_en, rsp_valid 19 cycles after core_en, rsp_id=0, rsp_err=0, rsp_* equal core values.
REQ-018 All four req high, core latency 5 -> grant order 0,1,2,3,0; each period 8 cycles; rsp_id matches ack order.
REQ-019 Core never asserts valid, TIMEOUT=64 -> rsp_valid with rsp_err=1, rsp data 0, 66 cycles after core_en; next request served normally.
REQ-020 rst driven low during WAIT, core_valid pulsed 3 cycles after release -> all outputs 0, no rsp_valid, busy=0.
REQ-021 core_valid pulsed in IDLE and in ISSUE -> no state change, no rsp_valid; only WAIT valid captured.
REQ-022 req[2] dropped in cycle after IDLE sampling -> transaction still issued and responded with rsp_id=2.
